// File: rtl/capture_pkg.sv
// Shared types and defaults for the six-channel sample capture buffer.
package capture_pkg;

    localparam int DEF_NUM_CH     = 6;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_TRIG_LEVEL = 128;
    localparam int DEF_TRIG_TMO   = 65535;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Channel k (k=0 is channel 1) out of a packed simultaneous sample set.
    function automatic logic [DEF_DATA_W-1:0] ch_slice(
        input logic [DEF_NUM_CH*DEF_DATA_W-1:0] data,
        input int unsigned                      k
    );
        return data[k*DEF_DATA_W +: DEF_DATA_W];
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// A read of an address being written in the same cycle returns the old word.
module sample_ram #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_capture_buffer.sv
// Triggered frame capture of six ADC channels into block RAM, aligned to a rising
// mid-scale crossing of channel 1, with a change-driven read port for the processor.
module sample_capture_buffer
    import capture_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int TRIG_LEVEL = DEF_TRIG_LEVEL,
    parameter int TRIG_TMO   = DEF_TRIG_TMO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     adc_valid,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic [ADDR_W-1:0]        read_address,
    output logic [NUM_CH*DATA_W-1:0] channel_data,
    output logic                     read_new_sample,
    output logic                     writing_finish_flag,
    output logic                     capturing
);

    localparam int W     = NUM_CH * DATA_W;
    localparam int TMO_W = (TRIG_TMO > 1) ? $clog2(TRIG_TMO) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [DATA_W-1:0] prev_ch1;
    logic [DATA_W-1:0] cur_ch1;
    logic              crossing;
    logic              tmo_hit;
    logic              start_capture;
    logic              last_write;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [W-1:0]      ram_rdata;

    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_primed;
    logic              rd_pend1;
    logic              in_done;
    logic              rd_req;
    logic              serve;

    assign cur_ch1       = ch_slice(adc_data, 0);
    assign crossing      = (prev_ch1 < DATA_W'(TRIG_LEVEL)) && (cur_ch1 >= DATA_W'(TRIG_LEVEL));
    assign tmo_hit       = (tmo_cnt == TMO_W'(TRIG_TMO - 1));
    assign start_capture = (state_q == WAIT_TRIG) && adc_valid && !arm && (crossing || tmo_hit);
    assign last_write    = &wr_ptr;

    // Read protocol: read_address is sampled every cycle; in DONE, a sampled address that
    // differs from the last requested one (or the first cycle in DONE) issues a RAM read.
    // Two cycles after sampling, channel_data loads and read_new_sample pulses once, unless
    // a newer request or an arm arrived in between, in which case the older read is dropped.
    assign in_done = (state_q == DONE) && !arm;
    assign rd_req  = in_done && (!rd_primed || (rd_addr_q != last_addr));
    assign serve   = in_done && rd_pend1 && !rd_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = WAIT_TRIG;
        end else begin
            case (state_q)
                WAIT_TRIG: if (start_capture)             state_d = CAPTURE;
                CAPTURE:   if (adc_valid && last_write)   state_d = DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        capturing = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        case (state_q)
            WAIT_TRIG: begin
                if (start_capture) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                end
            end
            CAPTURE: begin
                if (adc_valid && !arm) begin
                    ram_we = 1'b1;
                end
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr              <= '0;
            tmo_cnt             <= '0;
            prev_ch1            <= '0;
            writing_finish_flag <= 1'b0;
        end else begin
            if (adc_valid) begin
                prev_ch1 <= cur_ch1;
            end
            if (arm) begin
                wr_ptr  <= '0;
                tmo_cnt <= '0;
            end else if (state_q == WAIT_TRIG && adc_valid) begin
                if (start_capture) begin
                    wr_ptr  <= ADDR_W'(1);
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end else if (state_q == CAPTURE && adc_valid) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            writing_finish_flag <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q       <= '0;
            last_addr       <= '0;
            rd_primed       <= 1'b0;
            rd_pend1        <= 1'b0;
            channel_data    <= '0;
            read_new_sample <= 1'b0;
        end else begin
            rd_addr_q       <= read_address;
            rd_primed       <= in_done;
            rd_pend1        <= rd_req;
            read_new_sample <= serve;
            if (rd_req) begin
                last_addr <= rd_addr_q;
            end
            if (serve) begin
                channel_data <= ram_rdata;
            end
        end
    end

    sample_ram #(
        .WIDTH  (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (adc_data),
        .re    (rd_req),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

endmodule
